matrix_subtraction_stream: RTL and testbench
============================================

# matrix_subtraction_stream

Element-serial matrix subtraction engine: the inverse of the combinational matrix adder. It accepts one (A[i][j], B[i][j]) element pair per handshake in row-major order and emits D[i][j] = A[i][j] − B[i][j] on a valid/ready output stream, tagged with row/column indices and an end-of-matrix marker. A 2-entry output buffer decouples producer and consumer backpressure. It sits between the matrix feed logic and downstream accumulate/store stages, so wide matrix arrays need not be routed combinationally.

## Interface
- N, default 3: matrix dimension (N×N elements per matrix), N ≥ 2
- W, default 8: element width in bits
- IW, derived $clog2(N): index width (non-overridable local parameter)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  element pair present
- in_ready  output  1  engine can accept a pair this cycle
- in_a  input  W  element A[i][j], unsigned
- in_b  input  W  element B[i][j], unsigned
- out_valid  output  1  difference element present
- out_ready  input  1  consumer accepts the element this cycle
- out_d  output  W  (A − B) mod 2^W
- out_neg  output  1  borrow: in_a < in_b for this element
- out_row  output  IW  row index i of this element
- out_col  output  IW  column index j of this element
- out_last  output  1  element is D[N−1][N−1]
- out_any_neg  output  1  valid with out_last: some element of this matrix borrowed

## Operation
- Input accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Input position counters row/col reset to 0. Each accept: col increments; at col = N−1, col wraps to 0 and row increments; at (N−1, N−1), both wrap to 0. Counters never move without an accept.
- On accept: compute d = in_a − in_b over W+1 bits; out_d = low W bits; out_neg = bit W. Push {d, neg, row, col, last, any_neg} into the output FIFO.
- any_neg accumulator: sticky OR of neg over the current matrix. The entry pushed for the last element carries (accumulator | its own neg); the accumulator then clears to 0. out_any_neg is 0 on non-last entries.
- Output FIFO: 2 entries, in-order. out_* fields are driven from the head entry only. out_valid = FIFO non-empty.
- in_ready = FIFO not full, computed from registered occupancy only, with no combinational path from out_ready.
- Simultaneous push and pop in the same cycle: legal at any occupancy below 2. Occupancy stays unchanged and order is preserved.
- Holding rule: while out_valid && !out_ready, all out_* fields hold stable.
- Reset mid-matrix: row/col, accumulator, and FIFO all clear. The partial matrix is discarded, and the next accepted pair is element (0,0).

## Timing
- Reset values: in_ready = 1 (deasserts only when FIFO full), out_valid = 0, out_d = 0, out_neg = 0, out_row = 0, out_col = 0, out_last = 0, out_any_neg = 0.
- Latency: pair accepted at edge k is visible on out_* after edge k (cycle k+1). There is no combinational input-to-output path.
- Throughput: 1 element/cycle while out_ready is held high. One matrix takes N² cycles. Back-to-back matrices need no gap cycles.
- With out_ready low: two accepts fill the FIFO. in_ready falls in the cycle after the second accept and rises in the cycle after the first pop.
- in_valid with in_ready = 0: the pair is not consumed and counters do not move. The producer must hold its data.

## Test plan
- Reset, then N=3 stream pairs (a=10+k, b=k) for k=0..8 with out_ready=1 -> nine outputs of d=10, neg=0, row/col = (0,0)…(2,2), out_last only on the 9th, out_any_neg=0, one output per cycle, latency 1.
- Pair (3,5) at position (1,1), all other pairs (7,2) -> that element d=0xFE, neg=1; the last element has out_any_neg=1. A following matrix with no borrows -> out_any_neg=0 (accumulator cleared).
- Hold out_ready=0, drive 4 consecutive valid pairs -> exactly 2 accepted; in_ready=0 from the cycle after the 2nd accept; out_* stable. Release out_ready -> remaining pairs accepted in order with no loss or duplication.
- Random in_valid/out_ready toggling (~50%) over 5 back-to-back matrices -> output sequence matches the reference model (row-major order, wrap (2,2)->(0,0), exactly 5 out_last pulses).
- Assert reset after 4 accepts with FIFO occupancy 1 -> out_valid=0 immediately (asynchronous). After release, the next pair is tagged (0,0) and out_any_neg is clean.
- Boundary values: (0xFF,0x00) -> d=0xFF, neg=0; (0x00,0xFF) -> d=0x01, neg=1; (0x80,0x80) -> d=0, neg=0.

Source files
------------

// File: rtl/matrix_subtraction_stream_if.sv
// Stream bundle for the element-serial matrix subtractor: an (A, B) element-pair
// input channel and a tagged difference output channel, each with valid/ready.
interface matrix_subtraction_stream_if #(
  parameter int N = 3,
  parameter int W = 8
);
  localparam int IW = $clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_d;
  logic          out_neg;
  logic [IW-1:0] out_row;
  logic [IW-1:0] out_col;
  logic          out_last;
  logic          out_any_neg;

  // Environment side: produces pairs and consumes differences.
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_d, out_neg, out_row, out_col, out_last, out_any_neg
  );

  // Engine side.
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_d, out_neg, out_row, out_col, out_last, out_any_neg
  );
endinterface

// File: rtl/matrix_subtraction_stream.sv
// Element-serial matrix subtraction engine. Accepts one (A[i][j], B[i][j]) pair per
// handshake in row-major order and emits D = A - B with borrow, row/column tags, an
// end-of-matrix marker and a per-matrix "some element borrowed" flag. A two-entry
// output buffer (head/tail registers) decouples the two handshakes; every output is
// taken straight from a register, so there is no combinational path from any input.
module matrix_subtraction_stream #(
  parameter int N = 3,
  parameter int W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  matrix_subtraction_stream_if.slave    bus
);
  localparam int IW = $clog2(N);
  // Buffer entry layout, MSB first: {d, neg, row, col, last, any_neg}.
  localparam int EW = W + 2 * IW + 3;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [IW-1:0] r_row;
  logic [IW-1:0] r_col;
  logic          r_acc;
  logic [EW-1:0] r_head;
  logic [EW-1:0] r_tail;
  logic [1:0]    r_count;
  logic          r_in_ready;
  logic          r_out_valid;

  logic          w_push;
  logic          w_pop;
  logic [W:0]    w_diff;
  logic          w_neg;
  logic          w_last;
  logic          w_any;
  logic [EW-1:0] w_entry;
  logic [IW-1:0] w_row_nxt;
  logic [IW-1:0] w_col_nxt;
  logic          w_acc_nxt;
  logic [EW-1:0] w_head_nxt;
  logic [EW-1:0] w_tail_nxt;
  logic [1:0]    w_count_nxt;

  // Handshakes use only registered occupancy, so in_ready never depends on out_ready.
  assign w_push = bus.in_valid & r_in_ready;
  assign w_pop  = r_out_valid & bus.out_ready;

  // Difference over W+1 bits; the extra MSB is the borrow. Tag with the current position.
  always_comb begin
    w_diff  = {1'b0, bus.in_a} - {1'b0, bus.in_b};
    w_neg   = w_diff[W];
    w_last  = (r_row == LAST_IDX) && (r_col == LAST_IDX);
    if (w_last) begin
      w_any = r_acc | w_neg;
    end else begin
      w_any = 1'b0;
    end
    w_entry = {w_diff[W-1:0], w_neg, r_row, r_col, w_last, w_any};
  end

  // Row-major position walk and sticky borrow accumulator; both advance only on accept.
  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    w_acc_nxt = r_acc;
    if (w_push) begin
      if (w_last) begin
        w_row_nxt = {IW{1'b0}};
        w_col_nxt = {IW{1'b0}};
        w_acc_nxt = 1'b0;
      end else if (r_col == LAST_IDX) begin
        w_row_nxt = r_row + IW'(1);
        w_col_nxt = {IW{1'b0}};
        w_acc_nxt = r_acc | w_neg;
      end else begin
        w_row_nxt = r_row;
        w_col_nxt = r_col + IW'(1);
        w_acc_nxt = r_acc | w_neg;
      end
    end else begin
      w_row_nxt = r_row;
      w_col_nxt = r_col;
      w_acc_nxt = r_acc;
    end
  end

  // Two-entry in-order buffer: head feeds the outputs, tail holds the second entry.
  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10: begin
        if (r_count == 2'd0) begin
          w_head_nxt = w_entry;
        end else begin
          w_tail_nxt = w_entry;
        end
        w_count_nxt = r_count + 2'd1;
      end
      2'b01: begin
        if (r_count == 2'd2) begin
          w_head_nxt = r_tail;
        end else begin
          w_head_nxt = r_head;
        end
        w_count_nxt = r_count - 2'd1;
      end
      2'b11: begin
        // Push is blocked when full, so occupancy is 1 here: the new entry becomes head.
        if (r_count == 2'd1) begin
          w_head_nxt = w_entry;
        end else begin
          w_head_nxt = r_tail;
          w_tail_nxt = w_entry;
        end
        w_count_nxt = r_count;
      end
      default: begin
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count;
      end
    endcase
  end

  // State update; reset discards any partial matrix and empties the buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row       <= {IW{1'b0}};
      r_col       <= {IW{1'b0}};
      r_acc       <= 1'b0;
      r_head      <= {EW{1'b0}};
      r_tail      <= {EW{1'b0}};
      r_count     <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_acc       <= w_acc_nxt;
      r_head      <= w_head_nxt;
      r_tail      <= w_tail_nxt;
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt != 2'd2);
      r_out_valid <= (w_count_nxt != 2'd0);
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_d       = r_head[EW-1 -: W];
  assign bus.out_neg     = r_head[2*IW+2];
  assign bus.out_row     = r_head[2*IW+1 -: IW];
  assign bus.out_col     = r_head[IW+1 -: IW];
  assign bus.out_last    = r_head[1];
  assign bus.out_any_neg = r_head[0];
endmodule

// File: tb/tb_matrix_subtraction_stream.sv
// Bench for matrix_subtraction_stream: directed and randomised streams checked every
// cycle against a queue-based model, plus hand-computed literal expectations.
module tb_matrix_subtraction_stream;
  localparam int N  = 3;
  localparam int W  = 8;
  localparam int IW = $clog2(N);

  typedef struct packed {
    logic [W-1:0]  d;
    logic          neg;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic          last;
    logic          anyn;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  logic rnd_ready;
  logic fixed_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  ent_t exp_q[$];
  ent_t log_q[$];
  int   m_idx  = 0;
  logic m_flag = 1'b0;
  ent_t m_e;
  ent_t m_got;
  int   a_i;
  int   b_i;

  matrix_subtraction_stream_if #(.N(N), .W(W)) bus ();

  matrix_subtraction_stream #(.N(N), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Consumer: either a fixed ready level or a coin toss per cycle.
  always @(posedge clk) begin
    #2;
    if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
    else           bus.out_ready = fixed_ready;
  end

  // Reference model and per-cycle comparison, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_idx  = 0;
      m_flag = 1'b0;
    end else begin
      check("in_ready", bus.in_ready, exp_q.size() < 2);
      check("out_valid", bus.out_valid, exp_q.size() != 0);
      if (bus.out_valid && exp_q.size() != 0) begin
        m_e   = exp_q[0];
        m_got = '{d: bus.out_d, neg: bus.out_neg, row: bus.out_row, col: bus.out_col,
                  last: bus.out_last, anyn: bus.out_any_neg};
        check("out_d", m_got.d, m_e.d);
        check("out_neg", m_got.neg, m_e.neg);
        check("out_row", m_got.row, m_e.row);
        check("out_col", m_got.col, m_e.col);
        check("out_last", m_got.last, m_e.last);
        check("out_any_neg", m_got.anyn, m_e.anyn);
        if (bus.out_ready) begin
          log_q.push_back(m_got);
          void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        a_i       = int'(bus.in_a);
        b_i       = int'(bus.in_b);
        m_e.d     = W'((a_i - b_i + (1 << W)) % (1 << W));
        m_e.neg   = (a_i < b_i);
        m_e.row   = IW'(m_idx / N);
        m_e.col   = IW'(m_idx % N);
        m_e.last  = (m_idx == N * N - 1);
        m_flag    = m_flag | m_e.neg;
        m_e.anyn  = m_e.last ? m_flag : 1'b0;
        exp_q.push_back(m_e);
        m_idx++;
        if (m_e.last) begin
          m_idx  = 0;
          m_flag = 1'b0;
        end
      end
    end
  end

  // Present a pair and hold it until accepted (bounded).
  task automatic send(input int a, input int b);
    logic rdy;
    int   k;
    bus.in_valid = 1'b1;
    bus.in_a     = W'(a);
    bus.in_b     = W'(b);
    k = 0;
    forever begin
      rdy = bus.in_ready;
      @(posedge clk); #1;
      if (rdy) break;
      k++;
      if (k > 100) begin
        check("send_timeout", k, 0);
        break;
      end
    end
  endtask

  task automatic send_rnd(input int a, input int b);
    if ($urandom_range(0, 1) == 1) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(1, 2)) begin
        @(posedge clk); #1;
      end
    end
    send(a, b);
  endtask

  task automatic drain();
    int k;
    bus.in_valid = 1'b0;
    k = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int base;
    int acc;
    int lasts;
    logic rdy;
    reset        = 1'b1;
    rnd_ready    = 1'b0;
    fixed_ready  = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_d", bus.out_d, 0);
    check("rst_out_neg", bus.out_neg, 0);
    check("rst_out_row", bus.out_row, 0);
    check("rst_out_col", bus.out_col, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_any_neg", bus.out_any_neg, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Streaming matrix, no borrows: latency one cycle, d = 10 everywhere.
    base = log_q.size();
    send(10, 0);
    check("t1_latency_valid", bus.out_valid, 1);
    check("t1_latency_d", bus.out_d, 10);
    for (int k = 1; k < 9; k++) send(10 + k, k);
    drain();
    check("t1_first_row", log_q[base].row, 0);
    check("t1_first_col", log_q[base].col, 0);
    check("t1_mid_last", log_q[base + 7].last, 0);
    check("t1_end_last", log_q[base + 8].last, 1);
    check("t1_end_row", log_q[base + 8].row, 2);
    check("t1_end_col", log_q[base + 8].col, 2);
    check("t1_end_d", log_q[base + 8].d, 10);
    check("t1_end_any", log_q[base + 8].anyn, 0);

    // Single borrow at (1,1), then a clean matrix.
    base = log_q.size();
    for (int k = 0; k < 9; k++) begin
      if (k == 4) send(3, 5);
      else        send(7, 2);
    end
    for (int k = 0; k < 9; k++) send(7, 2);
    drain();
    check("t2_borrow_d", log_q[base + 4].d, 8'hFE);
    check("t2_borrow_neg", log_q[base + 4].neg, 1);
    check("t2_borrow_row", log_q[base + 4].row, 1);
    check("t2_borrow_col", log_q[base + 4].col, 1);
    check("t2_plain_d", log_q[base + 3].d, 5);
    check("t2_nonlast_any", log_q[base + 4].anyn, 0);
    check("t2_last_any", log_q[base + 8].anyn, 1);
    check("t2_next_last_any", log_q[base + 17].anyn, 0);

    // Consumer stalled: only two of four offered pairs get in.
    base = log_q.size();
    fixed_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = W'(20 + acc);
      bus.in_b     = W'(acc);
      rdy = bus.in_ready;
      @(posedge clk); #1;
      if (rdy) acc++;
    end
    check("t3_accepts", acc, 2);
    check("t3_in_ready_low", bus.in_ready, 0);
    check("t3_head_held_d", bus.out_d, 20);
    check("t3_head_held_col", bus.out_col, 0);
    fixed_ready = 1'b1;
    for (int k = 2; k < 9; k++) send(20 + k, k);
    drain();
    check("t3_count", log_q.size() - base, 9);
    check("t3_third_col", log_q[base + 2].col, 2);
    check("t3_third_d", log_q[base + 2].d, 20);
    check("t3_last", log_q[base + 8].last, 1);

    // Random handshakes over five back-to-back matrices.
    base = log_q.size();
    rnd_ready = 1'b1;
    for (int k = 0; k < 5 * N * N; k++) send_rnd($urandom_range(0, 255), $urandom_range(0, 255));
    bus.in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rnd_ready = 1'b0;
    @(posedge clk); #1;
    drain();
    lasts = 0;
    for (int i = base; i < log_q.size(); i++) if (log_q[i].last) lasts++;
    check("t4_outputs", log_q.size() - base, 5 * N * N);
    check("t4_last_pulses", lasts, 5);

    // Reset mid-matrix with one entry buffered (element (1,0)); borrow seen before reset.
    send(0, 1);
    send(5, 1);
    send(5, 1);
    send(5, 1);
    check("t5_pre_valid", bus.out_valid, 1);
    check("t5_pre_row", bus.out_row, 1);
    check("t5_pre_col", bus.out_col, 0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("t5_rst_valid", bus.out_valid, 0);
    check("t5_rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Boundary values, restarting at (0,0) with a clean accumulator.
    base = log_q.size();
    send(8'hFF, 8'h00);
    for (int k = 0; k < 7; k++) send(7, 2);
    send(8'h80, 8'h80);
    send(8'h00, 8'hFF);
    for (int k = 0; k < 8; k++) send(7, 2);
    drain();
    check("t6_ff00_row", log_q[base].row, 0);
    check("t6_ff00_col", log_q[base].col, 0);
    check("t6_ff00_d", log_q[base].d, 8'hFF);
    check("t6_ff00_neg", log_q[base].neg, 0);
    check("t6_8080_d", log_q[base + 8].d, 0);
    check("t6_8080_neg", log_q[base + 8].neg, 0);
    check("t6_clean_any", log_q[base + 8].anyn, 0);
    check("t6_00ff_d", log_q[base + 9].d, 8'h01);
    check("t6_00ff_neg", log_q[base + 9].neg, 1);
    check("t6_borrow_any", log_q[base + 17].anyn, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end
endmodule
